// File: rtl/cg_stream_pkg.sv
// Shared sizing, FSM encoding and padding-mask helper for the CG vector streamer.
package cg_stream_pkg;

  localparam int NUM_EQ      = 10;
  localparam int NO_OF_UNITS = 8;
  localparam int ELEM_W      = 32;
  localparam int CHUNK_W     = ELEM_W * NO_OF_UNITS;
  localparam int DEPTH       = (NUM_EQ + NO_OF_UNITS - 1) / NO_OF_UNITS;
  localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W       = $clog2(DEPTH + 1);
  localparam int ADDR_W      = IDX_W + 1;
  localparam int PAD_LANES   = NUM_EQ % NO_OF_UNITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Keeps lanes below valid_lanes; zero valid_lanes means the last chunk is full.
  function automatic logic [CHUNK_W-1:0] pad_mask(input int unsigned valid_lanes);
    logic [CHUNK_W-1:0] m;
    m = '0;
    for (int i = 0; i < NO_OF_UNITS; i++) begin
      if ((valid_lanes == 0) || (i < valid_lanes)) begin
        m[i*ELEM_W +: ELEM_W] = {ELEM_W{1'b1}};
      end else begin
        m[i*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/cg_bank_ram.sv
// 1W1R synchronous RAM holding both vector banks, addressed {bank, index}.
module cg_bank_ram
  import cg_stream_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [CHUNK_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [CHUNK_W-1:0] rdata
);

  logic [CHUNK_W-1:0] mem_r [2*DEPTH];

  // Storage array write port; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register holds its value while re is low, which gives stall stability.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/cg_vector_streamer.sv
// Ping-pong vector store: writes fill the shadow bank, reads stream the active bank.
// Optional macro CG_PAD_ZERO_EN zeroes padding lanes of the final chunk.
module cg_vector_streamer
  import cg_stream_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [CHUNK_W-1:0] wr_data,
  input  logic               swap,
  input  logic               rd_start,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [CHUNK_W-1:0] rd_data,
  output logic               rd_last,
  output logic               rd_done,
  output logic               busy,
  output logic               wr_overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t             state_r;
  logic [IDX_W-1:0]   rd_addr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic               active_r;
  logic               swap_pending_r;
  logic               rd_valid_r;
  logic               rd_last_r;
  logic               rd_done_r;
  logic               busy_r;
  logic               wr_overflow_r;

  logic               wr_fire_s;
  logic               swap_now_s;
  logic               ram_re_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [ADDR_W-1:0]  ram_raddr_s;
  logic [ADDR_W-1:0]  ram_waddr_s;
  logic [CHUNK_W-1:0] ram_q_s;

  // RAM control: read the current chunk in FETCH, prefetch the next one on accept.
  always_comb begin
    wr_fire_s   = wr_en && (wr_ptr_r < PTR_W'(DEPTH));
    ram_waddr_s = {~active_r, wr_ptr_r[IDX_W-1:0]};
    swap_now_s  = 1'b0;
    ram_re_s    = 1'b0;
    rd_idx_s    = rd_addr_r;
    case (state_r)
      IDLE:    swap_now_s = swap;
      FETCH:   ram_re_s   = 1'b1;
      STREAM: begin
        ram_re_s = rd_ready && (rd_addr_r != LAST_IDX);
        rd_idx_s = rd_addr_r + IDX_W'(1);
      end
      DONE:    swap_now_s = swap || swap_pending_r;
      default: swap_now_s = 1'b0;
    endcase
    ram_raddr_s = {active_r, rd_idx_s};
  end

  cg_bank_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_fire_s),
    .waddr (ram_waddr_s),
    .wdata (wr_data),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_q_s)
  );

  // Read FSM, write pointer, bank select and all status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      rd_addr_r      <= '0;
      wr_ptr_r       <= '0;
      active_r       <= 1'b0;
      swap_pending_r <= 1'b0;
      rd_valid_r     <= 1'b0;
      rd_last_r      <= 1'b0;
      rd_done_r      <= 1'b0;
      busy_r         <= 1'b0;
      wr_overflow_r  <= 1'b0;
    end else begin
      rd_done_r <= 1'b0;
      // A write in the swap cycle has already targeted the old shadow bank.
      if (swap_now_s) begin
        active_r <= ~active_r;
        wr_ptr_r <= '0;
      end else if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (wr_en && !wr_fire_s) begin
        wr_overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          swap_pending_r <= 1'b0;
          if (rd_start) begin
            state_r   <= FETCH;
            rd_addr_r <= '0;
            busy_r    <= 1'b1;
          end
        end
        FETCH: begin
          if (swap) swap_pending_r <= 1'b1;
          state_r    <= STREAM;
          rd_valid_r <= 1'b1;
          rd_last_r  <= (rd_addr_r == LAST_IDX);
        end
        STREAM: begin
          if (swap) swap_pending_r <= 1'b1;
          if (rd_ready) begin
            if (rd_addr_r == LAST_IDX) begin
              state_r    <= DONE;
              rd_valid_r <= 1'b0;
              rd_last_r  <= 1'b0;
              rd_done_r  <= 1'b1;
            end else begin
              rd_addr_r <= rd_addr_r + IDX_W'(1);
              rd_last_r <= ((rd_addr_r + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        DONE: begin
          state_r        <= IDLE;
          swap_pending_r <= 1'b0;
          busy_r         <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          rd_valid_r <= 1'b0;
          rd_last_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CG_PAD_ZERO_EN
  localparam logic [CHUNK_W-1:0] LAST_MASK = pad_mask(PAD_LANES);

  // Padding lanes of the final chunk read as zero so dot products ignore them.
  always_comb begin
    if (rd_last_r) begin
      rd_data = ram_q_s & LAST_MASK;
    end else begin
      rd_data = ram_q_s;
    end
  end
`else
  assign rd_data = ram_q_s;
`endif

  assign rd_valid    = rd_valid_r;
  assign rd_last     = rd_last_r;
  assign rd_done     = rd_done_r;
  assign busy        = busy_r;
  assign wr_overflow = wr_overflow_r;

endmodule

// File: tb/tb_cg_vector_streamer.sv
// Directed self-checking bench for cg_vector_streamer (NUM_EQ=10, 8 lanes, DEPTH=2).
module tb_cg_vector_streamer;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [255:0] wr_data;
  logic         swap;
  logic         rd_start;
  logic         rd_ready;
  logic         rd_valid;
  logic [255:0] rd_data;
  logic         rd_last;
  logic         rd_done;
  logic         busy;
  logic         wr_overflow;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] VA   = {8{32'hAAAA_AAAA}};
  localparam logic [255:0] VB   = {8{32'hBBBB_BBBB}};
  localparam logic [255:0] VC   = {8{32'hCCCC_CCCC}};
  localparam logic [255:0] VD   = {8{32'hDDDD_DDDD}};
  localparam logic [255:0] VE   = {8{32'hEEEE_EEEE}};
  localparam logic [255:0] VF   = {32'h0000_0008, 32'h0000_0007, 32'h0000_0006, 32'h0000_0005,
                                   32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
  localparam logic [255:0] VG   = {8{32'h9999_9999}};
  localparam logic [255:0] ONES = {8{32'hFFFF_FFFF}};

  cg_vector_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .swap        (swap),
    .rd_start    (rd_start),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_done     (rd_done),
    .busy        (busy),
    .wr_overflow (wr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected last chunk: 10 % 8 = 2 live lanes when padding is zeroed.
  function automatic logic [255:0] exp_last(input logic [255:0] v);
`ifdef CG_PAD_ZERO_EN
    return {192'd0, v[63:0]};
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 256'd0; swap = 1'b0;
    rd_start = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", {255'd0, rd_valid}, 256'd0);
    chk("rst_last", {255'd0, rd_last}, 256'd0);
    chk("rst_done", {255'd0, rd_done}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_ovf", {255'd0, wr_overflow}, 256'd0);
    chk("rst_data", rd_data, 256'd0);

    // 1: write A,B, swap, stream at full rate
    wr_en = 1'b1; wr_data = VA; tick();
    wr_data = VB; tick();
    wr_en = 1'b0; swap = 1'b1; tick();
    swap = 1'b0;
    chk("t1_idle_busy", {255'd0, busy}, 256'd0);
    rd_start = 1'b1; rd_ready = 1'b1; tick();
    rd_start = 1'b0;
    chk("t1_fetch_valid", {255'd0, rd_valid}, 256'd0);
    chk("t1_fetch_busy", {255'd0, busy}, 256'd1);
    tick();
    chk("t1_valid0", {255'd0, rd_valid}, 256'd1);
    chk("t1_data0", rd_data, VA);
    chk("t1_last0", {255'd0, rd_last}, 256'd0);
    tick();
    chk("t1_valid1", {255'd0, rd_valid}, 256'd1);
    chk("t1_data1", rd_data, exp_last(VB));
    chk("t1_last1", {255'd0, rd_last}, 256'd1);
    tick();
    chk("t1_done", {255'd0, rd_done}, 256'd1);
    chk("t1_done_valid", {255'd0, rd_valid}, 256'd0);
    tick();
    chk("t1_done_pulse", {255'd0, rd_done}, 256'd0);
    chk("t1_end_busy", {255'd0, busy}, 256'd0);

    // 2: ready pattern 1,0,0,1 holds chunk B stable
    rd_start = 1'b1; tick();
    rd_start = 1'b0; tick();
    chk("t2_data0", rd_data, VA);
    tick();
    chk("t2_data1", rd_data, exp_last(VB));
    rd_ready = 1'b0; tick();
    chk("t2_stall1_valid", {255'd0, rd_valid}, 256'd1);
    chk("t2_stall1_data", rd_data, exp_last(VB));
    tick();
    chk("t2_stall2_data", rd_data, exp_last(VB));
    chk("t2_stall2_last", {255'd0, rd_last}, 256'd1);
    rd_ready = 1'b1; tick();
    chk("t2_done", {255'd0, rd_done}, 256'd1);
    tick();
    chk("t2_idle_valid", {255'd0, rd_valid}, 256'd0);
    chk("t2_idle_done", {255'd0, rd_done}, 256'd0);

    // 3: fill shadow bank with C,D then overflow with E
    wr_en = 1'b1; wr_data = VC; tick();
    wr_data = VD; tick();
    chk("t3_no_ovf", {255'd0, wr_overflow}, 256'd0);
    wr_data = VE; tick();
    chk("t3_ovf", {255'd0, wr_overflow}, 256'd1);
    wr_en = 1'b0; tick();
    chk("t3_ovf_sticky", {255'd0, wr_overflow}, 256'd1);

    // 4: swap mid-stream; rest of stream from old bank, then new data
    rd_start = 1'b1; tick();
    rd_start = 1'b0; tick();
    chk("t4_data0", rd_data, VA);
    swap = 1'b1; tick();
    swap = 1'b0;
    chk("t4_data1_old", rd_data, exp_last(VB));
    chk("t4_busy", {255'd0, busy}, 256'd1);
    tick();
    chk("t4_done", {255'd0, rd_done}, 256'd1);
    tick();
    chk("t4_idle_busy", {255'd0, busy}, 256'd0);
    rd_start = 1'b1; tick();
    rd_start = 1'b0; tick();
    chk("t4_new0", rd_data, VC);
    tick();
    chk("t4_new1", rd_data, exp_last(VD));
    tick(); tick();
    chk("t4_ovf_sticky", {255'd0, wr_overflow}, 256'd1);

    // 5: last chunk all ones, written in the same cycle as swap
    wr_en = 1'b1; wr_data = VF; tick();
    wr_data = ONES; swap = 1'b1; tick();
    wr_en = 1'b0; swap = 1'b0;
    rd_start = 1'b1; tick();
    rd_start = 1'b0; tick();
    chk("t5_data0", rd_data, VF);
    tick();
    chk("t5_pad", rd_data, exp_last(ONES));
    tick(); tick();

    // 5b: rd_start with swap in IDLE streams the freshly swapped bank
    wr_en = 1'b1; wr_data = VG; tick();
    wr_en = 1'b0; rd_start = 1'b1; swap = 1'b1; tick();
    rd_start = 1'b0; swap = 1'b0; tick();
    chk("t5b_data0", rd_data, VG);
    tick();
    chk("t5b_data1", rd_data, exp_last(VD));
    tick(); tick();

    // 6: reset during STREAM
    rd_start = 1'b1; tick();
    rd_start = 1'b0; tick();
    chk("t6_streaming", {255'd0, rd_valid}, 256'd1);
    reset = 1'b1; tick();
    chk("t6_valid", {255'd0, rd_valid}, 256'd0);
    chk("t6_busy", {255'd0, busy}, 256'd0);
    chk("t6_done", {255'd0, rd_done}, 256'd0);
    chk("t6_ovf", {255'd0, wr_overflow}, 256'd0);
    reset = 1'b0; tick();
    chk("t6_no_done", {255'd0, rd_done}, 256'd0);
    chk("t6_idle_valid", {255'd0, rd_valid}, 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
